// File: rtl/neuron_mac_sekvencer.sv
// Sign-magnitude MAC sequencer for a 60-input neuron sharing one external multiplier.
// Optional bias stage enabled with macro NEURON_PRISTRANOST_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start; samples are latched on acceptance
// MAC       | k = 0..59 drives the weight ROM address, accumulates product k-1
// DRAIN     | accumulates the last product (weight 59 arriving from the ROM)
// BIAS      | adds the bias magnitude to P or N (only with the bias feature)
// USPOREDBA | registers |P-N| and its sign
// GOTOVO    | one-cycle done pulse
module neuron_mac_sekvencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         prekid,
  input  logic [959:0] uzorak,
  output logic [5:0]   tez_adr,
  input  logic [15:0]  tez_podatak,
  output logic [15:0]  mnoz_tezina,
  output logic [15:0]  mnoz_uzorak,
  input  logic [15:0]  mnoz_produkt,
  output logic [21:0]  suma,
  output logic         predznak,
  output logic         zauzet,
`ifdef NEURON_PRISTRANOST_EN
  input  logic [15:0]  pristranost,
`endif
  output logic         gotovo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
`ifdef NEURON_PRISTRANOST_EN
    S_BIAS,
`endif
    S_USPOREDBA,
    S_GOTOVO
  } stanje_t;

  stanje_t        state_q;
  logic [5:0]     k_q;
  logic [21:0]    p_q, n_q;
  logic [21:0]    p_d, n_d;
  logic [959:0]   uzorak_q;
  logic [21:0]    suma_q;
  logic           predznak_q;

  logic           acc_en;
  logic [5:0]     idx;
  logic [21:0]    prod_ext;

  // ROM data lags the address by one cycle, so the product in flight belongs to k-1
  assign acc_en   = ((state_q == S_MAC) && (k_q != 6'd0)) || (state_q == S_DRAIN);
  assign idx      = k_q - 6'd1;
  assign prod_ext = {6'd0, mnoz_produkt};

  always_comb begin
    p_d = p_q;
    n_d = n_q;
    if (acc_en) begin
      if (tez_podatak[15]) n_d = n_q + prod_ext;
      else                 p_d = p_q + prod_ext;
    end
`ifdef NEURON_PRISTRANOST_EN
    if (state_q == S_BIAS) begin
      if (pristranost[15]) n_d = n_q + {7'd0, pristranost[14:0]};
      else                 p_d = p_q + {7'd0, pristranost[14:0]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 6'd0;
      p_q        <= 22'd0;
      n_q        <= 22'd0;
      uzorak_q   <= 960'd0;
      suma_q     <= 22'd0;
      predznak_q <= 1'b0;
    end else if (prekid && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !prekid) begin
            uzorak_q <= uzorak;
            k_q      <= 6'd0;
            p_q      <= 22'd0;
            n_q      <= 22'd0;
            state_q  <= S_MAC;
          end
        end
        S_MAC: begin
          k_q <= k_q + 6'd1;
          p_q <= p_d;
          n_q <= n_d;
          if (k_q == 6'd59) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          p_q <= p_d;
          n_q <= n_d;
`ifdef NEURON_PRISTRANOST_EN
          state_q <= S_BIAS;
`else
          state_q <= S_USPOREDBA;
`endif
        end
`ifdef NEURON_PRISTRANOST_EN
        S_BIAS: begin
          p_q     <= p_d;
          n_q     <= n_d;
          state_q <= S_USPOREDBA;
        end
`endif
        S_USPOREDBA: begin
          // a tie reports as negative
          if (p_q > n_q) begin
            suma_q     <= p_q - n_q;
            predznak_q <= 1'b0;
          end else begin
            suma_q     <= n_q - p_q;
            predznak_q <= 1'b1;
          end
          state_q <= S_GOTOVO;
        end
        S_GOTOVO: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign tez_adr     = (state_q == S_MAC) ? k_q : 6'd0;
  assign mnoz_tezina = acc_en ? {1'b0, tez_podatak[14:0]} : 16'd0;
  assign mnoz_uzorak = acc_en ? uzorak_q[{idx, 4'b0000} +: 16] : 16'd0;
  assign suma        = suma_q;
  assign predznak    = predznak_q;
  assign zauzet      = (state_q != S_IDLE);
  assign gotovo      = (state_q == S_GOTOVO);

endmodule

// File: tb/tb_neuron_mac_sekvencer.sv
// Bench for neuron_mac_sekvencer: weight ROM and multiplier stub, timeline/result model,
// per-cycle compare process plus directed literal checks.
module tb_neuron_mac_sekvencer;

`ifdef NEURON_PRISTRANOST_EN
  localparam int LAT = 64;
`else
  localparam int LAT = 63;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic         prekid = 1'b0;
  logic [959:0] uzorak = '0;
  logic [5:0]   tez_adr;
  logic [15:0]  tez_podatak = '0;
  logic [15:0]  mnoz_tezina, mnoz_uzorak, mnoz_produkt;
  logic [21:0]  suma;
  logic         predznak, zauzet, gotovo;
  logic [15:0]  pristranost = 16'd0;

  logic [15:0]  rom [60];
  int           mode = 0;
  logic [15:0]  stub_val = 16'h0100;

  int tests = 0;
  int fails = 0;

  neuron_mac_sekvencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prekid(prekid), .uzorak(uzorak),
    .tez_adr(tez_adr), .tez_podatak(tez_podatak),
    .mnoz_tezina(mnoz_tezina), .mnoz_uzorak(mnoz_uzorak), .mnoz_produkt(mnoz_produkt),
    .suma(suma), .predznak(predznak), .zauzet(zauzet),
`ifdef NEURON_PRISTRANOST_EN
    .pristranost(pristranost),
`endif
    .gotovo(gotovo)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return (mode == 0) ? stub_val : full[15:0];
  endfunction

  assign mnoz_produkt = mul(mnoz_tezina, mnoz_uzorak);

  always @(posedge clk) tez_podatak <= rom[tez_adr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // model: c = cycles since the accepted start edge, -1 when idle
  int           c = -1;
  logic [959:0] lat_uz = '0;
  logic [21:0]  e_suma = '0;
  logic         e_pred = 1'b0;
  logic [21:0]  pend_s;
  logic         pend_p;

  task automatic evaluate();
    int p, n;
    logic [15:0] w, s, pr;
    p = 0; n = 0;
    for (int k = 0; k < 60; k++) begin
      w  = rom[k];
      s  = uzorak[16*k +: 16];
      pr = mul({1'b0, w[14:0]}, s);
      if (w[15]) n += int'(pr); else p += int'(pr);
    end
`ifdef NEURON_PRISTRANOST_EN
    if (pristranost[15]) n += int'(pristranost[14:0]); else p += int'(pristranost[14:0]);
`endif
    if (p > n) begin pend_s = 22'(p - n); pend_p = 1'b0; end
    else       begin pend_s = 22'(n - p); pend_p = 1'b1; end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = -1; e_suma = '0; e_pred = 1'b0; lat_uz = '0;
    end else if (c < 0) begin
      if (start && !prekid) begin
        evaluate();
        lat_uz = uzorak;
        c = 0;
      end
    end else if (prekid || c == LAT - 1) begin
      c = -1;
    end else begin
      c++;
      if (c == LAT - 1) begin e_suma = pend_s; e_pred = pend_p; end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ew, eu, rw;
    ew = 16'd0; eu = 16'd0;
    if (c >= 1 && c <= 60) begin
      rw = rom[c-1];
      ew = {1'b0, rw[14:0]};
      eu = lat_uz[16*(c-1) +: 16];
    end
    chk("zauzet", 32'(zauzet), 32'(c >= 0));
    chk("gotovo", 32'(gotovo), 32'(c == LAT - 1));
    chk("suma", 32'(suma), 32'(e_suma));
    chk("predznak", 32'(predznak), 32'(e_pred));
    chk("tez_adr", 32'(tez_adr), (c >= 0 && c <= 59) ? 32'(c) : 32'd0);
    chk("mnoz_tezina", 32'(mnoz_tezina), 32'(ew));
    chk("mnoz_uzorak", 32'(mnoz_uzorak), 32'(eu));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic run_eval(input string name, input logic chk_lit, input logic [21:0] es, input logic ep);
    int n;
    pulse_start();
    n = 0;
    while (!gotovo && n < 200) begin tick(1); n++; end
    chk({name, "_latency"}, 32'(n), 32'(LAT - 1));
    if (chk_lit) begin
      chk({name, "_suma"}, 32'(suma), 32'(es));
      chk({name, "_predznak"}, 32'(predznak), 32'(ep));
    end
    tick(1);
    chk({name, "_pulse_once"}, 32'(gotovo), 32'd0);
    tick(2);
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin tick(1); if (gotovo) pulses++; end
  endtask

  task automatic rom_mixed();
    for (int k = 0; k < 60; k++)
      rom[k] = (k < 24) ? {1'b0, 15'(k + 1)} : {1'b1, 15'(k * 7)};
  endtask

  task automatic rand_samples();
    for (int k = 0; k < 60; k++) uzorak[16*k +: 16] = 16'($urandom);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    rom_mixed();
    rand_samples();
    tick(3);
    chk("reset_suma", 32'(suma), 32'd0);
    chk("reset_zauzet", 32'(zauzet), 32'd0);
    chk("reset_mnoz", 32'({mnoz_tezina, mnoz_uzorak}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 24 positive / 36 negative weights, constant product 256
    mode = 0; stub_val = 16'h0100;
    run_eval("stub100", 1'b1, 22'd3072, 1'b1);

    // zero product: tie resolves negative, single pulse
    stub_val = 16'h0000;
    pulse_start();
    count_pulses(100, pulses);
    chk("stub0_pulses", 32'(pulses), 32'd1);
    chk("stub0_suma", 32'(suma), 32'd0);
    chk("stub0_predznak", 32'(predznak), 32'd1);

    // all positive, full-scale product
    for (int k = 0; k < 60; k++) rom[k] = {1'b0, 15'(k + 100)};
    stub_val = 16'hFFFF;
    run_eval("allpos", 1'b1, 22'h3BFFC4, 1'b0);

    // prekid with start in IDLE: stay idle
    start = 1'b1; prekid = 1'b1; tick(1); start = 1'b0; prekid = 1'b0;
    chk("prekid_idle_zauzet", 32'(zauzet), 32'd0);

    // abort mid-MAC, then a clean run
    rom_mixed(); stub_val = 16'h0100;
    pulse_start();
    tick(29);
    prekid = 1'b1; tick(1); prekid = 1'b0;
    chk("abort_zauzet", 32'(zauzet), 32'd0);
    count_pulses(70, pulses);
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_suma_held", 32'(suma), 32'd3932100);
    chk("abort_predznak_held", 32'(predznak), 32'd0);
    run_eval("after_abort", 1'b1, 22'd3072, 1'b1);

    // reset mid-MAC, start on the first edge after release, repeated start ignored
    pulse_start();
    tick(19);
    rst_n = 1'b0; #1;
    chk("rst_async_suma", 32'(suma), 32'd0);
    chk("rst_async_pred", 32'(predznak), 32'd0);
    chk("rst_async_zauzet", 32'(zauzet), 32'd0);
    chk("rst_async_adr", 32'(tez_adr), 32'd0);
    tick(2);
    rst_n = 1'b1; start = 1'b1; tick(1); start = 1'b0;
    chk("first_start_zauzet", 32'(zauzet), 32'd1);
    tick(10);
    pulse_start();
    count_pulses(120, pulses);
    chk("rst_run_pulses", 32'(pulses), 32'd1);
    chk("rst_run_suma", 32'(suma), 32'd3072);

    // real products against random weights and samples
    mode = 1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 60; k++) rom[k] = 16'($urandom);
      rand_samples();
      run_eval("random", 1'b0, 22'd0, 1'b0);
    end

`ifdef NEURON_PRISTRANOST_EN
    mode = 0; stub_val = 16'h0100; rom_mixed();
    pristranost = 16'h0C00;
    run_eval("bias", 1'b1, 22'd0, 1'b1);
    pristranost = 16'h8C00;
    run_eval("bias_neg", 1'b1, 22'd6144, 1'b1);
    pristranost = 16'd0;
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
